// File: rtl/udt_state_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : udt_state_arbiter_if
//  Purpose  : Bundles the writer-side and reader-side handshake signals of the
//             UDT connection-state arbiter into one interface.
//  Modports : slave  - arbiter view (consumes writer requests and reader acks,
//                      drives accept strobes, state word and broadcast flags)
//             master - environment view (writers + readers)
//  Signals  : value_i  WR_NUM*DW  writer w state word at [w*DW +: DW]
//             valid_i  WR_NUM     writer w requests an update
//             ready_o  WR_NUM     one-hot accept strobe to the granted writer
//             value_o  DW         current authoritative state word
//             valid_o  RD_NUM     reader r has an unconsumed update
//             ready_i  RD_NUM     reader r consumes its update
//             grant_id GW         index of the last accepted writer
//             busy_o   1          any reader still holds an update
//  Revision : 1.0 - initial release
// ============================================================================
interface udt_state_arbiter_if #(
    parameter int WR_NUM = 3,
    parameter int RD_NUM = 1,
    parameter int DW     = 32
);
    localparam int GW = (WR_NUM > 1) ? $clog2(WR_NUM) : 1;

    logic [WR_NUM*DW-1:0] value_i;
    logic [WR_NUM-1:0]    valid_i;
    logic [WR_NUM-1:0]    ready_o;
    logic [DW-1:0]        value_o;
    logic [RD_NUM-1:0]    valid_o;
    logic [RD_NUM-1:0]    ready_i;
    logic [GW-1:0]        grant_id;
    logic                 busy_o;

    modport slave (
        input  value_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output value_o,
        output valid_o,
        output grant_id,
        output busy_o
    );

    modport master (
        output value_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  value_o,
        input  valid_o,
        input  grant_id,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/udt_state_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udt_state_arbiter
//  Purpose  : Arbitrates UDT connection-state updates from WR_NUM writers into
//             one authoritative state register using a fair round-robin
//             grant, then broadcasts every accepted update to RD_NUM readers.
//             A new write is only accepted once every reader has consumed the
//             current update, so no update is ever lost.
//  Ports    : core_clk  clock, rising edge
//             core_rst  synchronous reset, active-high
//             bus       udt_state_arbiter_if.slave (writer/reader handshakes,
//                       state word, grant index, busy flag)
//  Options  : `UDT_STATE_SAME_SKIP_EN - a write whose value equals the current
//             state is still accepted (ready pulse, grant_id updated) but is
//             not broadcast. Undefined: every accepted write is broadcast.
//  Revision : 1.0 - initial release
// ============================================================================
module udt_state_arbiter #(
    parameter int              WR_NUM    = 3,
    parameter int              RD_NUM    = 1,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   RST_VALUE = '0
) (
    input  wire logic          core_clk,
    input  wire logic          core_rst,
    udt_state_arbiter_if.slave bus
);

    localparam int GW = (WR_NUM > 1) ? $clog2(WR_NUM) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BCAST = 1'b1
    } state_t;

    state_t              r_fsm;
    logic [DW-1:0]       r_state;
    logic [RD_NUM-1:0]   r_valid;
    logic [GW-1:0]       r_grant_id;

    logic                w_found;
    logic [GW-1:0]       w_gnt;
    logic [GW-1:0]       w_idx;
    logic [WR_NUM-1:0]   w_gnt_onehot;
    logic [DW-1:0]       w_gnt_value;
    logic                w_accept;
    logic                w_skip;
    logic [RD_NUM-1:0]   w_valid_next;

    // Writer index 'step' positions after 'base', wrapping at WR_NUM.
    // Works for non-power-of-two writer counts.
    function automatic logic [GW-1:0] f_rr_next(input logic [GW-1:0] base,
                                                 input int            step);
        int t;
        t = int'(base) + step;
        if (t >= WR_NUM) begin
            t = t - WR_NUM;
        end
        return GW'(t);
    endfunction

    // Round-robin search: the writer right after the last grant has the
    // highest priority, the last granted writer the lowest.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_grant_id;
        w_idx   = '0;
        for (int k = 1; k <= WR_NUM; k++) begin
            w_idx = f_rr_next(r_grant_id, k);
            if (!w_found && bus.valid_i[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt_onehot = WR_NUM'(1) << w_gnt;
        w_gnt_value  = bus.value_i[int'(w_gnt)*DW +: DW];
    end

    // Accept only in IDLE and never while reset is asserted, so a writer can
    // not believe its update landed when reset is about to discard it.
    assign w_accept = (r_fsm == S_IDLE) && w_found && !core_rst;

`ifdef UDT_STATE_SAME_SKIP_EN
    assign w_skip = (w_gnt_value == r_state);
`else
    assign w_skip = 1'b0;
`endif

    // Acks on bits that are already clear have no effect.
    assign w_valid_next = r_valid & ~bus.ready_i;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_fsm      <= S_IDLE;
            r_state    <= RST_VALUE;
            r_valid    <= '0;
            r_grant_id <= GW'(WR_NUM - 1);
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant_id <= w_gnt;
                        if (!w_skip) begin
                            r_state <= w_gnt_value;
                            r_valid <= '1;
                            r_fsm   <= S_BCAST;
                        end
                    end
                end
                S_BCAST: begin
                    r_valid <= w_valid_next;
                    if (w_valid_next == '0) begin
                        r_fsm <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready_o  = w_accept ? w_gnt_onehot : '0;
    assign bus.value_o  = r_state;
    assign bus.valid_o  = r_valid;
    assign bus.grant_id = r_grant_id;
    assign bus.busy_o   = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_udt_state_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udt_state_arbiter
//  Purpose  : Self-checking bench for udt_state_arbiter. Three instances:
//             dut1 (3 writers, 1 reader), dut2 (3 writers, 2 readers) and
//             dut3 (1 writer, 1 reader). Granted values are pushed to a
//             per-instance queue and popped when the reader sees them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udt_state_arbiter;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;

    always #5 core_clk = ~core_clk;

    udt_state_arbiter_if #(.WR_NUM(3), .RD_NUM(1), .DW(32)) bus1 ();
    udt_state_arbiter_if #(.WR_NUM(3), .RD_NUM(2), .DW(32)) bus2 ();
    udt_state_arbiter_if #(.WR_NUM(1), .RD_NUM(1), .DW(32)) bus3 ();

    udt_state_arbiter #(.WR_NUM(3), .RD_NUM(1), .DW(32), .RST_VALUE(32'h0)) dut1 (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus1.slave)
    );

    udt_state_arbiter #(.WR_NUM(3), .RD_NUM(2), .DW(32), .RST_VALUE(32'h0)) dut2 (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus2.slave)
    );

    udt_state_arbiter #(.WR_NUM(1), .RD_NUM(1), .DW(32), .RST_VALUE(32'h0)) dut3 (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus3.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb1[$];
    logic [31:0] sb2[$];
    logic [31:0] sb3[$];
    logic [31:0] exp_v;

    // Inputs change just after a rising edge; outputs are checked on the
    // falling edge.
    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge core_clk);
    endtask

    task automatic do_reset();
        core_rst = 1'b1;
        step();
        core_rst = 1'b0;
    endtask

    task automatic test_reset();
        bus1.valid_i = 3'b111;
        bus1.value_i = '0;
        bus1.ready_i = '0;
        bus2.valid_i = '0;
        bus2.value_i = '0;
        bus2.ready_i = '0;
        bus3.valid_i = '0;
        bus3.value_i = '0;
        bus3.ready_i = '0;
        core_rst     = 1'b1;
        step();
        step();
        settle();
        n_tests++; if (bus1.value_o !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h expected %h", bus1.value_o, 32'h0); end
        n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus1.valid_o); end
        n_tests++; if (bus1.ready_o !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", bus1.ready_o); end
        n_tests++; if (bus1.grant_id !== 2'd2) begin n_fail++; $display("FAIL reset_grant: got %0d expected 2", bus1.grant_id); end
        n_tests++; if (bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus1.busy_o); end
        n_tests++; if (bus2.valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid2: got %b expected 00", bus2.valid_o); end
        n_tests++; if (bus3.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant3: got %0d expected 0", bus3.grant_id); end
        bus1.valid_i = '0;
        step();
        core_rst = 1'b0;
    endtask

    task automatic test_single_write();
        bus1.valid_i = 3'b010;
        bus1.value_i = {32'h0, 32'h5, 32'h0};
        settle();
        n_tests++; if (bus1.ready_o !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b expected 010", bus1.ready_o); end
        sb1.push_back(32'h5);
        step();
        bus1.valid_i = '0;
        settle();
        n_tests++; if (bus1.valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus1.valid_o); end
        n_tests++; if (bus1.grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", bus1.grant_id); end
        n_tests++; if (bus1.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus1.busy_o); end
        step();
        bus1.ready_i = 1'b1;
        settle();
        n_tests++; if (bus1.valid_o !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %b expected 1", bus1.valid_o); end
        exp_v = (sb1.size() > 0) ? sb1.pop_front() : 32'hx;
        n_tests++; if (bus1.value_o !== exp_v) begin n_fail++; $display("FAIL single_value: got %h expected %h", bus1.value_o, exp_v); end
        step();
        settle();
        n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %b expected 0", bus1.valid_o); end
        n_tests++; if (bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", bus1.busy_o); end
        step();
        bus1.ready_i = 1'b0;
    endtask

    task automatic test_fairness();
        logic [31:0] wr_val [3];
        int          exp_ptr;
        int          exp_w;
        do_reset();
        for (int w = 0; w < 3; w++) wr_val[w] = 32'h100 * (w + 1);
        bus1.value_i = {wr_val[2], wr_val[1], wr_val[0]};
        bus1.valid_i = 3'b111;
        bus1.ready_i = 1'b1;
        exp_ptr = 2;
        exp_w   = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            settle();
            if (cyc % 2 == 0) begin
                exp_w = (exp_ptr + 1) % 3;
                n_tests++; if (bus1.ready_o !== (3'b001 << exp_w)) begin n_fail++; $display("FAIL fair_grant cyc%0d: got %b expected %b", cyc, bus1.ready_o, 3'b001 << exp_w); end
                sb1.push_back(wr_val[exp_w]);
                exp_ptr = exp_w;
            end else begin
                n_tests++; if (bus1.ready_o !== 3'b000) begin n_fail++; $display("FAIL fair_gap cyc%0d: got %b expected 000", cyc, bus1.ready_o); end
                n_tests++; if (bus1.valid_o !== 1'b1) begin n_fail++; $display("FAIL fair_valid cyc%0d: got %b expected 1", cyc, bus1.valid_o); end
                exp_v = (sb1.size() > 0) ? sb1.pop_front() : 32'hx;
                n_tests++; if (bus1.value_o !== exp_v) begin n_fail++; $display("FAIL fair_value cyc%0d: got %h expected %h", cyc, bus1.value_o, exp_v); end
                n_tests++; if (bus1.grant_id !== 2'(exp_ptr)) begin n_fail++; $display("FAIL fair_gid cyc%0d: got %0d expected %0d", cyc, bus1.grant_id, exp_ptr); end
            end
            step();
            if (cyc % 2 == 0) begin
                wr_val[exp_w] = wr_val[exp_w] + 32'h1;
                bus1.value_i  = {wr_val[2], wr_val[1], wr_val[0]};
            end
        end
        bus1.valid_i = '0;
        step();
        bus1.ready_i = 1'b0;
    endtask

    task automatic test_multi_reader();
        do_reset();
        bus2.valid_i = 3'b101;
        bus2.value_i = {32'hC, 32'h0, 32'hA};
        bus2.ready_i = 2'b00;
        settle();
        n_tests++; if (bus2.ready_o !== 3'b001) begin n_fail++; $display("FAIL mr_grant0: got %b expected 001", bus2.ready_o); end
        sb2.push_back(32'hA);
        step();
        bus2.valid_i = 3'b100;
        bus2.ready_i = 2'b01;
        settle();
        n_tests++; if (bus2.valid_o !== 2'b11) begin n_fail++; $display("FAIL mr_valid_c1: got %b expected 11", bus2.valid_o); end
        exp_v = (sb2.size() > 0) ? sb2.pop_front() : 32'hx;
        n_tests++; if (bus2.value_o !== exp_v) begin n_fail++; $display("FAIL mr_value: got %h expected %h", bus2.value_o, exp_v); end
        for (int c = 2; c <= 4; c++) begin
            step();
            if (c == 4) bus2.ready_i = 2'b11;
            settle();
            n_tests++; if (bus2.valid_o !== 2'b10) begin n_fail++; $display("FAIL mr_valid_c%0d: got %b expected 10", c, bus2.valid_o); end
            n_tests++; if (bus2.ready_o !== 3'b000) begin n_fail++; $display("FAIL mr_early_grant_c%0d: got %b expected 000", c, bus2.ready_o); end
        end
        step();
        settle();
        n_tests++; if (bus2.valid_o !== 2'b00) begin n_fail++; $display("FAIL mr_valid_c5: got %b expected 00", bus2.valid_o); end
        n_tests++; if (bus2.ready_o !== 3'b100) begin n_fail++; $display("FAIL mr_grant2: got %b expected 100", bus2.ready_o); end
        sb2.push_back(32'hC);
        step();
        bus2.valid_i = '0;
        bus2.ready_i = 2'b00;
        settle();
        n_tests++; if (bus2.valid_o !== 2'b11) begin n_fail++; $display("FAIL mr_valid_c6: got %b expected 11", bus2.valid_o); end
        n_tests++; if (bus2.value_o !== sb2[0]) begin n_fail++; $display("FAIL mr_value2: got %h expected %h", bus2.value_o, sb2[0]); end
    endtask

    // Continues from test_multi_reader: dut2 is broadcasting with valid_o=11.
    task automatic test_reset_bcast();
        step();
        core_rst = 1'b1;
        settle();
        n_tests++; if (bus2.valid_o !== 2'b11) begin n_fail++; $display("FAIL rb_before: got %b expected 11", bus2.valid_o); end
        step();
        core_rst     = 1'b0;
        bus2.ready_i = 2'b11;
        sb2.delete();
        settle();
        n_tests++; if (bus2.valid_o !== 2'b00) begin n_fail++; $display("FAIL rb_valid: got %b expected 00", bus2.valid_o); end
        n_tests++; if (bus2.value_o !== 32'h0) begin n_fail++; $display("FAIL rb_value: got %h expected %h", bus2.value_o, 32'h0); end
        n_tests++; if (bus2.grant_id !== 2'd2) begin n_fail++; $display("FAIL rb_grant: got %0d expected 2", bus2.grant_id); end
        step();
        settle();
        n_tests++; if (bus2.valid_o !== 2'b00) begin n_fail++; $display("FAIL rb_stale: got %b expected 00", bus2.valid_o); end
        n_tests++; if (bus2.busy_o !== 1'b0) begin n_fail++; $display("FAIL rb_busy: got %b expected 0", bus2.busy_o); end
        step();
        bus2.ready_i = 2'b00;
    endtask

    task automatic test_same_value();
        do_reset();
        bus1.ready_i = 1'b1;
        bus1.valid_i = 3'b001;
        bus1.value_i = {32'h0, 32'h0, 32'h7};
        settle();
        sb1.push_back(32'h7);
        step();
        bus1.valid_i = '0;
        settle();
        exp_v = (sb1.size() > 0) ? sb1.pop_front() : 32'hx;
        n_tests++; if (bus1.value_o !== exp_v) begin n_fail++; $display("FAIL same_first: got %h expected %h", bus1.value_o, exp_v); end
        step();
        bus1.valid_i = 3'b001;
        settle();
        n_tests++; if (bus1.ready_o !== 3'b001) begin n_fail++; $display("FAIL same_ready: got %b expected 001", bus1.ready_o); end
        step();
        bus1.valid_i = '0;
        settle();
`ifdef UDT_STATE_SAME_SKIP_EN
        n_tests++; if (bus1.valid_o !== 1'b0) begin n_fail++; $display("FAIL same_skip: got %b expected 0", bus1.valid_o); end
        n_tests++; if (bus1.grant_id !== 2'd0) begin n_fail++; $display("FAIL same_grant: got %0d expected 0", bus1.grant_id); end
`else
        n_tests++; if (bus1.valid_o !== 1'b1) begin n_fail++; $display("FAIL same_bcast: got %b expected 1", bus1.valid_o); end
        n_tests++; if (bus1.value_o !== 32'h7) begin n_fail++; $display("FAIL same_value: got %h expected %h", bus1.value_o, 32'h7); end
`endif
        step();
        bus1.valid_i = 3'b010;
        bus1.value_i = {32'h0, 32'h9, 32'h7};
        settle();
        n_tests++; if (bus1.ready_o !== 3'b010) begin n_fail++; $display("FAIL diff_ready: got %b expected 010", bus1.ready_o); end
        step();
        bus1.valid_i = '0;
        settle();
        n_tests++; if (bus1.valid_o !== 1'b1 || bus1.value_o !== 32'h9) begin n_fail++; $display("FAIL diff_bcast: got %b/%h expected 1/%h", bus1.valid_o, bus1.value_o, 32'h9); end
        step();
        bus1.ready_i = 1'b0;
    endtask

    task automatic test_single_writer();
        do_reset();
        bus3.ready_i = 1'b1;
        bus3.valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus3.value_i = 32'h30 + 32'(i);
            settle();
            n_tests++; if (bus3.ready_o !== 1'b1) begin n_fail++; $display("FAIL sw_ready%0d: got %b expected 1", i, bus3.ready_o); end
            sb3.push_back(32'h30 + 32'(i));
            step();
            settle();
            exp_v = (sb3.size() > 0) ? sb3.pop_front() : 32'hx;
            n_tests++; if (bus3.valid_o !== 1'b1 || bus3.value_o !== exp_v) begin n_fail++; $display("FAIL sw_bcast%0d: got %b/%h expected 1/%h", i, bus3.valid_o, bus3.value_o, exp_v); end
            n_tests++; if (bus3.grant_id !== 1'b0 || bus3.ready_o !== 1'b0) begin n_fail++; $display("FAIL sw_gid%0d: got %0d/%b expected 0/0", i, bus3.grant_id, bus3.ready_o); end
            step();
        end
        bus3.valid_i = 1'b0;
        bus3.ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_multi_reader();
        test_reset_bcast();
        test_same_value();
        test_single_writer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
